// File: rtl/parking_meter_pkg.sv
// Shared constants, state encoding and saturation helper for the parking meter.
package parking_meter_pkg;

  localparam int TIME_W = 14;
  localparam int SUM_W  = 15;

  localparam int unsigned DEF_MAX_TIME = 9999;
  localparam int unsigned DEF_COIN0    = 50;
  localparam int unsigned DEF_COIN1    = 150;
  localparam int unsigned DEF_COIN2    = 200;
  localparam int unsigned DEF_COIN3    = 500;
  localparam int unsigned DEF_PRESET1  = 15;
  localparam int unsigned DEF_PRESET2  = 185;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  function automatic logic [TIME_W-1:0] sat_time(input logic [SUM_W-1:0] v,
                                                 input logic [SUM_W-1:0] max_v);
    if (v > max_v) return max_v[TIME_W-1:0];
    return v[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one async input.
// Edges are only armed once the synchronized level has been seen low after reset.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;
  logic fill1;
  logic fill2;
  logic armed;

  // fill1/fill2 mark when sync holds a real sample, so a level held high
  // through reset release never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      fill1  <= 1'b0;
      fill2  <= 1'b0;
      armed  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      fill1  <= 1'b1;
      fill2  <= fill1;
      if (fill2 && !sync) armed <= 1'b1;
      pulse  <= armed && sync && !sync_d;
    end
  end

endmodule

// File: rtl/time_accumulator.sv
// Turns coin and service-preset events into absolute load values offered to the
// decrementer over a valid/ready handshake, saturating at MAX_TIME.
module time_accumulator
  import parking_meter_pkg::*;
#(
  parameter int unsigned MAX_TIME = DEF_MAX_TIME,
  parameter int unsigned COIN0    = DEF_COIN0,
  parameter int unsigned COIN1    = DEF_COIN1,
  parameter int unsigned COIN2    = DEF_COIN2,
  parameter int unsigned COIN3    = DEF_COIN3,
  parameter int unsigned PRESET1  = DEF_PRESET1,
  parameter int unsigned PRESET2  = DEF_PRESET2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        coin,
  input  logic              preset1,
  input  logic              preset2,
  input  logic [TIME_W-1:0] Timein,
  input  logic              load_ready,
  output logic [TIME_W-1:0] time_load,
  output logic              load_valid,
  output logic              EA
);

  localparam logic [SUM_W-1:0]  MAX_S     = SUM_W'(MAX_TIME);
  localparam logic [SUM_W-1:0]  COIN0_S   = SUM_W'(COIN0);
  localparam logic [SUM_W-1:0]  COIN1_S   = SUM_W'(COIN1);
  localparam logic [SUM_W-1:0]  COIN2_S   = SUM_W'(COIN2);
  localparam logic [SUM_W-1:0]  COIN3_S   = SUM_W'(COIN3);
  localparam logic [TIME_W-1:0] PRESET1_T = TIME_W'(PRESET1);
  localparam logic [TIME_W-1:0] PRESET2_T = TIME_W'(PRESET2);

  function automatic logic [SUM_W-1:0] coin_sum(input logic [3:0] ev);
    logic [SUM_W-1:0] s;
    s = '0;
    if (ev[0]) s = s + COIN0_S;
    if (ev[1]) s = s + COIN1_S;
    if (ev[2]) s = s + COIN2_S;
    if (ev[3]) s = s + COIN3_S;
    return s;
  endfunction

  logic [3:0]        coin_evt;
  logic              p1_evt;
  logic              p2_evt;

  for (genvar i = 0; i < 4; i++) begin : g_coin
    edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (coin[i]),
      .pulse (coin_evt[i])
    );
  end

  edge_sync u_sync_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (preset1),
    .pulse (p1_evt)
  );

  edge_sync u_sync_p2 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (preset2),
    .pulse (p2_evt)
  );

  state_t            state;
  logic [TIME_W-1:0] base;
  logic [TIME_W-1:0] pending;
  logic [TIME_W-1:0] pend_snap;
  logic [3:0]        lat_coins;
  logic              lat_p1;
  logic              lat_p2;

  logic              preset_any;
  logic [TIME_W-1:0] preset_val;
  logic [TIME_W-1:0] pend_next;
  logic [TIME_W-1:0] add_result;
  logic              start;

  // preset2 beats preset1; the sum width leaves headroom so nothing wraps before saturation
  always_comb begin
    preset_any = p1_evt || p2_evt;
    preset_val = p2_evt ? PRESET2_T : PRESET1_T;
    pend_next  = sat_time({1'b0, pending} + coin_sum(coin_evt), MAX_S);
    add_result = sat_time({1'b0, base} + coin_sum(lat_coins) + {1'b0, pend_snap}, MAX_S);
    start      = (|coin_evt) || preset_any || (pending != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      time_load  <= '0;
      load_valid <= 1'b0;
      pending    <= '0;
      base       <= '0;
      pend_snap  <= '0;
      lat_coins  <= '0;
      lat_p1     <= 1'b0;
      lat_p2     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base      <= Timein;
            pend_snap <= pending;
            pending   <= '0;
            lat_coins <= coin_evt;
            lat_p1    <= p1_evt;
            lat_p2    <= p2_evt;
            state     <= ST_ADD;
          end
        end
        ST_ADD: begin
          load_valid <= 1'b1;
          state      <= ST_OFFER;
          if (preset_any) begin
            time_load <= preset_val;
            pending   <= '0;
          end else begin
            pending <= pend_next;
            if (lat_p2)      time_load <= PRESET2_T;
            else if (lat_p1) time_load <= PRESET1_T;
            else             time_load <= add_result;
          end
        end
        ST_OFFER: begin
          // A preset arriving while offering replaces the offer rather than completing it
          if (preset_any) begin
            time_load <= preset_val;
            pending   <= '0;
          end else begin
            pending <= pend_next;
            if (load_ready) begin
              load_valid <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          load_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign EA = (Timein != '0) && !load_valid;

endmodule

// File: tb/tb_time_accumulator.sv
// Directed bench for time_accumulator: expected loads are queued when stimulus is
// driven and popped when the DUT raises load_valid.
module tb_time_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  coin;
  logic        preset1;
  logic        preset2;
  logic [13:0] Timein;
  logic        load_ready;
  logic [13:0] time_load;
  logic        load_valid;
  logic        EA;

  int          errors = 0;
  int          checks = 0;
  logic [13:0] expq[$];

  time_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin       (coin),
    .preset1    (preset1),
    .preset2    (preset2),
    .Timein     (Timein),
    .load_ready (load_ready),
    .time_load  (time_load),
    .load_valid (load_valid),
    .EA         (EA)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs change on a falling edge and stay high for exactly one clock
  task automatic applyStimulus(input logic [3:0] c, input logic p1, input logic p2);
    coin    = c;
    preset1 = p1;
    preset2 = p2;
    @(negedge clk);
    coin    = 4'd0;
    preset1 = 1'b0;
    preset2 = 1'b0;
  endtask

  function automatic logic [13:0] popExp();
    if (expq.size() == 0) return 14'h3fff;
    return expq.pop_front();
  endfunction

  task automatic checkOffer(input string tag);
    int n = 0;
    while (load_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 16'(load_valid), 16'd1);
    checkOutput({tag, "_load"}, 16'(time_load), 16'(popExp()));
    checkOutput({tag, "_ea"}, 16'(EA), 16'd0);
  endtask

  initial begin
    int seen;
    int bad;

    rst_n = 1'b0; coin = 4'd0; preset1 = 1'b0; preset2 = 1'b0;
    Timein = 14'd0; load_ready = 1'b0;
    tick(2);
    checkOutput("rst_valid", 16'(load_valid), 16'd0);
    checkOutput("rst_load", 16'(time_load), 16'd0);
    checkOutput("rst_ea_zero", 16'(EA), 16'd0);
    Timein = 14'd1;
    #1 checkOutput("rst_ea_one", 16'(EA), 16'd1);
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // Single coin3 with exact latency and one-cycle handshake
    Timein = 14'd500; load_ready = 1'b1;
    expq.push_back(14'd1000);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick(3);
    checkOutput("t1_not_yet", 16'(load_valid), 16'd0);
    tick(1);
    checkOutput("t1_valid", 16'(load_valid), 16'd1);
    checkOutput("t1_load", 16'(time_load), 16'(popExp()));
    checkOutput("t1_ea", 16'(EA), 16'd0);
    tick(1);
    checkOutput("t1_one_cycle", 16'(load_valid), 16'd0);
    checkOutput("t1_ea_back", 16'(EA), 16'd1);

    // Simultaneous coins saturate
    Timein = 14'd9900;
    expq.push_back(14'd9999);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOffer("t2");
    tick(1);

    // Both presets: preset2 wins; preset1 alone
    Timein = 14'd300;
    expq.push_back(14'd185);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOffer("t3_both");
    tick(1);
    expq.push_back(14'd15);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOffer("t3_p1");
    tick(1);

    // Preset during OFFER replaces the load and discards pending coins
    load_ready = 1'b0; Timein = 14'd300;
    expq.push_back(14'd500);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOffer("t4_first");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick(4);
    checkOutput("t4_held_valid", 16'(load_valid), 16'd1);
    checkOutput("t4_held_load", 16'(time_load), 16'd500);
    expq.push_back(14'd185);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick(2);
    checkOutput("t4_before_preset", 16'(time_load), 16'd500);
    tick(1);
    checkOutput("t4_replaced_valid", 16'(load_valid), 16'd1);
    checkOutput("t4_replaced_load", 16'(time_load), 16'(popExp()));
    load_ready = 1'b1;
    tick(1);
    checkOutput("t4_accepted", 16'(load_valid), 16'd0);
    seen = 0;
    repeat (8) begin
      tick(1);
      if (load_valid) seen++;
    end
    checkOutput("t4_pending_cleared", 16'(seen), 16'd0);

    // Coins during OFFER go to pending and start a second transaction
    load_ready = 1'b0; Timein = 14'd700;
    expq.push_back(14'd850);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOffer("t5_first");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    bad = 0;
    repeat (6) begin
      tick(1);
      if (load_valid !== 1'b1 || time_load !== 14'd850) bad++;
    end
    checkOutput("t5_held_stable", 16'(bad), 16'd0);
    Timein = 14'd640; load_ready = 1'b1;
    expq.push_back(14'd740);
    tick(1);
    checkOutput("t5_release", 16'(load_valid), 16'd0);
    checkOffer("t5_second");
    tick(1);

    // Reset during OFFER aborts; a coin held through release is ignored
    load_ready = 1'b0; Timein = 14'd200;
    expq.push_back(14'd700);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOffer("t6_offer");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 16'(load_valid), 16'd0);
    checkOutput("t6_async_load", 16'(time_load), 16'd0);
    checkOutput("t6_ea_rst", 16'(EA), 16'd1);
    coin = 4'b0001;
    tick(2);
    rst_n = 1'b1;
    load_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick(1);
      if (load_valid) seen++;
    end
    checkOutput("t6_no_event", 16'(seen), 16'd0);
    coin = 4'd0;
    tick(5);
    expq.push_back(14'd250);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOffer("t6_fresh");
    tick(1);

    // Expired meter reloads from zero; EA follows Timein
    Timein = 14'd0;
    tick(1);
    checkOutput("t7_ea_zero", 16'(EA), 16'd0);
    Timein = 14'd1;
    #1 checkOutput("t7_ea_one", 16'(EA), 16'd1);
    tick(1);
    Timein = 14'd0;
    expq.push_back(14'd50);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOffer("t7_zero_base");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
